// File: rtl/mouse_pkg.sv
// Shared constants and helpers for the mouse pointer tracker.
// Default screen size, edge-mode encodings, button indices and acceleration threshold.
package mouse_pkg;

    localparam int H_RES_DEF    = 640;
    localparam int V_RES_DEF    = 480;

    localparam int EDGE_CLAMP   = 0;
    localparam int EDGE_WRAP    = 1;

    localparam int BTN_L        = 0;
    localparam int BTN_R        = 1;
    localparam int BTN_M        = 2;
    localparam int NUM_BTN      = 3;

    localparam int ACCEL_THRESH = 16;
    localparam int PKT_DW       = 9;

    // Magnitude of a packet delta; -256 needs the extra bit.
    function automatic logic [PKT_DW:0] delta_abs(input logic [PKT_DW-1:0] d);
        logic [PKT_DW:0] ext;
        ext = {d[PKT_DW-1], d};
        return d[PKT_DW-1] ? (~ext + 1'b1) : ext;
    endfunction

endpackage

// File: rtl/mouse_pos_tracker_if.sv
// Decoded PS/2 movement packet bus from the packet decoder into the tracker.
// master drives a packet with a one-cycle pkt_valid strobe; slave only listens.
interface mouse_pos_tracker_if;
    import mouse_pkg::*;

    logic                 pkt_valid;
    logic [PKT_DW-1:0]    pkt_dx;
    logic [PKT_DW-1:0]    pkt_dy;
    logic [1:0]           pkt_ovf;
    logic [NUM_BTN-1:0]   pkt_btn;

    modport master (
        output pkt_valid,
        output pkt_dx,
        output pkt_dy,
        output pkt_ovf,
        output pkt_btn
    );

    modport slave (
        input pkt_valid,
        input pkt_dx,
        input pkt_dy,
        input pkt_ovf,
        input pkt_btn
    );

endinterface

// File: rtl/mouse_axis_acc.sv
// One pointer axis: adds a signed delta to the held position, then clamps or wraps
// into 0..RES-1; a recenter (or reset) loads RES/2.
module mouse_axis_acc
    import mouse_pkg::*;
#(
    parameter int W         = 10,
    parameter int RES       = H_RES_DEF,
    parameter int EDGE_MODE = EDGE_CLAMP
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_upd,
    input  logic                i_recenter,
    input  logic signed [W+1:0] i_delta,
    output logic [W-1:0]        o_pos
);

    localparam logic [W-1:0]        CENTRE = W'(RES / 2);
    localparam logic signed [W+1:0] RES_S  = (W+2)'(RES);

    logic [W-1:0]        r_pos;
    logic signed [W+1:0] w_sum;
    logic [W-1:0]        w_fix;

    assign w_sum = $signed({2'b00, r_pos}) + i_delta;

    generate
        if (EDGE_MODE == EDGE_WRAP) begin : g_wrap
            // Delta magnitude is below RES, so a single correction lands in range.
            always_comb begin
                w_fix = W'(w_sum);
                if (w_sum < 0) begin
                    w_fix = W'(w_sum + RES_S);
                end else if (w_sum >= RES_S) begin
                    w_fix = W'(w_sum - RES_S);
                end
            end
        end else begin : g_clamp
            localparam logic signed [W+1:0] MAX_S = (W+2)'(RES - 1);
            localparam logic [W-1:0]        MAX_U = W'(RES - 1);

            always_comb begin
                w_fix = W'(w_sum);
                if (w_sum < 0) begin
                    w_fix = '0;
                end else if (w_sum > MAX_S) begin
                    w_fix = MAX_U;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pos <= CENTRE;
        end else if (i_recenter) begin
            r_pos <= CENTRE;
        end else if (i_upd) begin
            r_pos <= w_fix;
        end
    end

    assign o_pos = r_pos;

endmodule

// File: rtl/mouse_pos_tracker.sv
// Pointer-position accumulator: scales decoded PS/2 deltas, tracks X/Y and buttons.
// Optional MOUSE_ACCEL_EN doubles any axis delta whose packet magnitude exceeds 16.
module mouse_pos_tracker #(
    parameter int H_RES     = mouse_pkg::H_RES_DEF,
    parameter int V_RES     = mouse_pkg::V_RES_DEF,
    parameter int X_W       = 10,
    parameter int Y_W       = 9,
    parameter int SHIFT     = 0,
    parameter int EDGE_WRAP = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    mouse_pos_tracker_if.slave       pkt,
    input  logic                     recenter,
    output logic [X_W-1:0]           mouse_x,
    output logic [Y_W-1:0]           mouse_y,
    output logic [2:0]               btn,
    output logic [2:0]               click,
    output logic                     pos_upd
);
    import mouse_pkg::*;

    localparam int XD = X_W + 2;
    localparam int YD = Y_W + 2;

    logic                  r_s1_valid;
    logic signed [XD-1:0]  r_dx_s;
    logic signed [YD-1:0]  r_dy_s;
    logic [NUM_BTN-1:0]    r_btn_s1;
    logic                  r_pos_upd;

    logic signed [XD-1:0]  w_dx_ext;
    logic signed [XD-1:0]  w_dx_lin;
    logic signed [XD-1:0]  w_dx_scl;
    logic signed [YD-1:0]  w_dy_ext;
    logic signed [YD-1:0]  w_dy_lin;
    logic signed [YD-1:0]  w_dy_scl;
    logic                  w_stage2;

    assign w_dx_ext = XD'($signed(pkt.pkt_dx));
    assign w_dy_ext = YD'($signed(pkt.pkt_dy));
    assign w_dx_lin = w_dx_ext <<< SHIFT;
    // PS/2 reports +dy as up, screen rows grow downward.
    assign w_dy_lin = -(w_dy_ext <<< SHIFT);

`ifdef MOUSE_ACCEL_EN
    assign w_dx_scl = (delta_abs(pkt.pkt_dx) > (PKT_DW+1)'(ACCEL_THRESH)) ? (w_dx_lin <<< 1) : w_dx_lin;
    assign w_dy_scl = (delta_abs(pkt.pkt_dy) > (PKT_DW+1)'(ACCEL_THRESH)) ? (w_dy_lin <<< 1) : w_dy_lin;
`else
    assign w_dx_scl = w_dx_lin;
    assign w_dy_scl = w_dy_lin;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_dx_s     <= '0;
            r_dy_s     <= '0;
            r_btn_s1   <= '0;
        end else begin
            r_s1_valid <= pkt.pkt_valid;
            if (pkt.pkt_valid) begin
                r_dx_s   <= pkt.pkt_ovf[0] ? '0 : w_dx_scl;
                r_dy_s   <= pkt.pkt_ovf[1] ? '0 : w_dy_scl;
                r_btn_s1 <= pkt.pkt_btn;
            end
        end
    end

    // Recenter takes priority over the packet sitting in stage 1.
    assign w_stage2 = r_s1_valid & ~recenter;

    mouse_axis_acc #(
        .W         (X_W),
        .RES       (H_RES),
        .EDGE_MODE (EDGE_WRAP)
    ) u_axis_x (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_upd      (w_stage2),
        .i_recenter (recenter),
        .i_delta    (r_dx_s),
        .o_pos      (mouse_x)
    );

    mouse_axis_acc #(
        .W         (Y_W),
        .RES       (V_RES),
        .EDGE_MODE (EDGE_WRAP)
    ) u_axis_y (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_upd      (w_stage2),
        .i_recenter (recenter),
        .i_delta    (r_dy_s),
        .o_pos      (mouse_y)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BTN; gi++) begin : g_btn
            logic r_level;
            logic r_pulse;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_level <= 1'b0;
                    r_pulse <= 1'b0;
                end else if (w_stage2) begin
                    r_level <= r_btn_s1[gi];
                    r_pulse <= r_btn_s1[gi] & ~r_level;
                end else begin
                    r_pulse <= 1'b0;
                end
            end

            assign btn[gi]   = r_level;
            assign click[gi] = r_pulse;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pos_upd <= 1'b0;
        end else begin
            r_pos_upd <= r_s1_valid | recenter;
        end
    end

    assign pos_upd = r_pos_upd;

endmodule

// File: tb/tb_mouse_pos_tracker.sv
// Scoreboard bench: a clamp-mode and a wrap-mode tracker share one packet stream;
// expected updates are queued at issue time and checked whenever pos_upd fires.
`timescale 1ns/1ps
module tb_mouse_pos_tracker;
    import mouse_pkg::*;

`ifdef MOUSE_ACCEL_EN
    localparam bit ACCEL = 1'b1;
`else
    localparam bit ACCEL = 1'b0;
`endif

    typedef struct {
        int cyc;
        int x;
        int y;
        int b;
        int c;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       recenter;
    logic [9:0] x_a, x_b;
    logic [8:0] y_a, y_b;
    logic [2:0] btn_a, btn_b, click_a, click_b;
    logic       upd_a, upd_b;

    exp_t qa[$];
    exp_t qb[$];
    int   cyc     = 0;
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mouse_pos_tracker_if pkt_if ();

    mouse_pos_tracker #(
        .H_RES(640), .V_RES(480), .X_W(10), .Y_W(9), .SHIFT(0), .EDGE_WRAP(0)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .pkt(pkt_if), .recenter(recenter),
        .mouse_x(x_a), .mouse_y(y_a), .btn(btn_a), .click(click_a), .pos_upd(upd_a)
    );

    mouse_pos_tracker #(
        .H_RES(640), .V_RES(480), .X_W(10), .Y_W(9), .SHIFT(0), .EDGE_WRAP(1)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .pkt(pkt_if), .recenter(recenter),
        .mouse_x(x_b), .mouse_y(y_b), .btn(btn_b), .click(click_b), .pos_upd(upd_b)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic compare_txn(input string tag, input exp_t e, input int x, input int y,
                               input int b, input int c);
        $display("txn %s cyc=%0d x=%0d y=%0d btn=%0d click=%0d", tag, cyc, x, y, b, c);
        chk({tag, " latency"}, cyc, e.cyc);
        chk({tag, " mouse_x"}, x, e.x);
        chk({tag, " mouse_y"}, y, e.y);
        chk({tag, " btn"}, b, e.b);
        chk({tag, " click"}, c, e.c);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1) begin
            if (upd_a === 1'b1) begin
                if (qa.size() == 0) chk("A unexpected pos_upd", 1, 0);
                else begin
                    e = qa.pop_front();
                    compare_txn("A", e, int'(x_a), int'(y_a), int'(btn_a), int'(click_a));
                end
            end else if (qa.size() > 0 && qa[0].cyc <= cyc) begin
                e = qa.pop_front();
                chk("A missing pos_upd", 0, 1);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1) begin
            if (upd_b === 1'b1) begin
                if (qb.size() == 0) chk("B unexpected pos_upd", 1, 0);
                else begin
                    e = qb.pop_front();
                    compare_txn("B", e, int'(x_b), int'(y_b), int'(btn_b), int'(click_b));
                end
            end else if (qb.size() > 0 && qb[0].cyc <= cyc) begin
                e = qb.pop_front();
                chk("B missing pos_upd", 0, 1);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            pkt_if.pkt_valid = 1'b0;
            recenter         = 1'b0;
        end
    endtask

    task automatic drive_pkt(input int dx, input int dy, input logic [1:0] ovf, input logic [2:0] b);
        pkt_if.pkt_valid = 1'b1;
        pkt_if.pkt_dx    = 9'(dx);
        pkt_if.pkt_dy    = 9'(dy);
        pkt_if.pkt_ovf   = ovf;
        pkt_if.pkt_btn   = b;
    endtask

    task automatic send(input int dx, input int dy, input logic [1:0] ovf, input logic [2:0] b,
                        input int xa, input int ya, input int xb, input int yb,
                        input int eb, input int ec);
        @(posedge clk); #1;
        recenter = 1'b0;
        drive_pkt(dx, dy, ovf, b);
        qa.push_back(exp_t'{cyc + 2, xa, ya, eb, ec});
        qb.push_back(exp_t'{cyc + 2, xb, yb, eb, ec});
    endtask

    task automatic do_recenter(input int eb);
        @(posedge clk); #1;
        pkt_if.pkt_valid = 1'b0;
        recenter         = 1'b1;
        qa.push_back(exp_t'{cyc + 1, 320, 240, eb, 0});
        qb.push_back(exp_t'{cyc + 1, 320, 240, eb, 0});
    endtask

    initial begin
        rst_n            = 1'b0;
        recenter         = 1'b0;
        pkt_if.pkt_valid = 1'b0;
        pkt_if.pkt_dx    = '0;
        pkt_if.pkt_dy    = '0;
        pkt_if.pkt_ovf   = '0;
        pkt_if.pkt_btn   = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2);

        @(negedge clk);
        chk("reset mouse_x", int'(x_a), 320);
        chk("reset mouse_y", int'(y_a), 240);
        chk("reset btn", int'(btn_a), 0);
        chk("reset click", int'(click_a), 0);
        chk("reset pos_upd", int'(upd_a), 0);
        chk("reset wrap mouse_x", int'(x_b), 320);
        chk("reset wrap mouse_y", int'(y_b), 240);

        // Basic move: right 10, up 5.
        send(10, 5, 2'b00, 3'b000, 330, 235, 330, 235, 0, 0);
        idle(4);

        // Four back-to-back left moves from centre: clamp vs wrap.
        do_recenter(0);
        idle(2);
        send(-100, 0, 2'b00, 3'b000, ACCEL ? 120 : 220, 240, ACCEL ? 120 : 220, 240, 0, 0);
        send(-100, 0, 2'b00, 3'b000, ACCEL ? 0 : 120,   240, ACCEL ? 560 : 120, 240, 0, 0);
        send(-100, 0, 2'b00, 3'b000, ACCEL ? 0 : 20,    240, ACCEL ? 360 : 20,  240, 0, 0);
        send(-100, 0, 2'b00, 3'b000, 0,                 240, ACCEL ? 160 : 560, 240, 0, 0);
        idle(3);

        // X overflow flag suppresses dx; dy=-3 moves down three rows.
        do_recenter(0);
        idle(2);
        send(200, -3, 2'b01, 3'b000, 320, 243, 320, 243, 0, 0);
        idle(3);

        // Button-only packets and click edges.
        send(0, 0, 2'b00, 3'b000, 320, 243, 320, 243, 0, 0);
        send(0, 0, 2'b00, 3'b001, 320, 243, 320, 243, 1, 1);
        send(0, 0, 2'b00, 3'b001, 320, 243, 320, 243, 1, 0);
        send(0, 0, 2'b00, 3'b011, 320, 243, 320, 243, 3, 2);
        idle(3);

        // Recenter drops the stage-1 packet but captures the concurrent one.
        @(posedge clk); #1;
        drive_pkt(50, 0, 2'b00, 3'b011);
        @(posedge clk); #1;
        recenter = 1'b1;
        drive_pkt(1, 0, 2'b00, 3'b011);
        qa.push_back(exp_t'{cyc + 1, 320, 240, 3, 0});
        qb.push_back(exp_t'{cyc + 1, 320, 240, 3, 0});
        qa.push_back(exp_t'{cyc + 2, 321, 240, 3, 0});
        qb.push_back(exp_t'{cyc + 2, 321, 240, 3, 0});
        idle(3);

        // Right and top screen edges.
        send(255, 0, 2'b00, 3'b011, ACCEL ? 639 : 576, 240, ACCEL ? 191 : 576, 240, 3, 0);
        send(255, 0, 2'b00, 3'b011, 639, 240, ACCEL ? 61 : 191, 240, 3, 0);
        send(0, 255, 2'b00, 3'b011, 639, 0, ACCEL ? 61 : 191, ACCEL ? 210 : 465, 3, 0);
        idle(3);

`ifdef MOUSE_ACCEL_EN
        do_recenter(3);
        idle(2);
        send(20, 0, 2'b00, 3'b011, 360, 240, 360, 240, 3, 0);
        send(16, 0, 2'b00, 3'b011, 376, 240, 376, 240, 3, 0);
        idle(3);
`endif

        // Reset while a packet sits in stage 1: it must vanish.
        @(posedge clk); #1;
        drive_pkt(7, 0, 2'b00, 3'b011);
        @(posedge clk); #1;
        pkt_if.pkt_valid = 1'b0;
        rst_n            = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(4);
        @(negedge clk);
        chk("mid reset mouse_x", int'(x_a), 320);
        chk("mid reset mouse_y", int'(y_a), 240);
        chk("mid reset btn", int'(btn_a), 0);
        chk("mid reset wrap mouse_x", int'(x_b), 320);
        chk("mid reset wrap mouse_y", int'(y_b), 240);
        chk("A pending updates", qa.size(), 0);
        chk("B pending updates", qb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
